// File: rtl/stepper_pulsegen_if.sv
// rtl/stepper_pulsegen_if.sv - register-file side bundle of one joint's step/dir generator
// velocity_in and position carry two's-complement values.
interface stepper_pulsegen_if #(
  parameter int FREQ_BITS = 32,
  parameter int POS_BITS  = 32
);
  logic [FREQ_BITS-1:0] velocity_in;
  logic                 velocity_load;
  logic                 enable;
  logic                 pos_clear;
  logic                 stp;
  logic                 dir;
  logic [POS_BITS-1:0]  position;
  logic                 busy;
  logic                 overrun;

  modport master (
    output velocity_in, velocity_load, enable, pos_clear,
    input  stp, dir, position, busy, overrun
  );

  modport slave (
    input  velocity_in, velocity_load, enable, pos_clear,
    output stp, dir, position, busy, overrun
  );
endinterface

// File: rtl/stepper_pulsegen.sv
// rtl/stepper_pulsegen.sv - DDS step/dir generator with pulse timing FSM and position counter
// A carry out of the phase accumulator becomes a pending step that the FSM turns into a timed pulse.
module stepper_pulsegen #(
  parameter int FREQ_BITS        = 32,
  parameter int POS_BITS         = 32,
  parameter int PULSE_CYCLES     = 100,
  parameter int DIR_SETUP_CYCLES = 50
) (
  input  logic sysclk,
  input  logic rst_n,
  stepper_pulsegen_if.slave bus
);

  localparam int TMAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [FREQ_BITS-1:0] vel_q;
  logic [FREQ_BITS-1:0] acc_q, acc_d;
  logic                 pending_q, pending_d;
  logic                 pend_dir_q, pend_dir_d;
  logic                 overrun_q, overrun_d;
  logic                 dir_q, dir_d;
  logic [POS_BITS-1:0]  pos_q, pos_d;
  logic                 stp_q, busy_q;

  logic [FREQ_BITS-1:0] neg_vel, mag;
  logic [FREQ_BITS:0]   sum;
  logic                 carry, accept, entering;
  logic [POS_BITS-1:0]  pos_base;

  // Negating the most-negative word overflows back to itself; clamp it to the largest positive rate.
  always_comb begin
    neg_vel = -vel_q;
    if (!vel_q[FREQ_BITS-1])
      mag = vel_q;
    else if (neg_vel[FREQ_BITS-1])
      mag = {1'b0, {(FREQ_BITS-1){1'b1}}};
    else
      mag = neg_vel;
    sum   = {1'b0, acc_q} + {1'b0, mag};
    carry = bus.enable && sum[FREQ_BITS];
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    acc_d      = acc_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    overrun_d  = overrun_q;
    dir_d      = dir_q;
    accept     = bus.enable && pending_q && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pend_dir_q == dir_q) begin
            state_d = STEP_HIGH;
            timer_d = TW'(PULSE_CYCLES);
          end else begin
            dir_d   = pend_dir_q;
            state_d = DIR_SETUP;
            timer_d = TW'(DIR_SETUP_CYCLES);
          end
        end
      end
      DIR_SETUP: begin
        if (timer_q <= TW'(1)) begin
          state_d = STEP_HIGH;
          timer_d = TW'(PULSE_CYCLES);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STEP_HIGH: begin
        if (timer_q <= TW'(1)) begin
          state_d = STEP_LOW;
          timer_d = TW'(PULSE_CYCLES);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        if (timer_q <= TW'(1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase

    // A carry landing on the accept cycle re-arms pending rather than counting as lost.
    if (!bus.enable) begin
      acc_d     = '0;
      pending_d = 1'b0;
    end else begin
      acc_d = sum[FREQ_BITS-1:0];
      if (accept)
        pending_d = 1'b0;
      if (carry) begin
        if (pending_q && !accept) begin
          overrun_d = 1'b1;
        end else begin
          pending_d  = 1'b1;
          pend_dir_d = vel_q[FREQ_BITS-1];
        end
      end
    end

    entering = (state_d == STEP_HIGH) && (state_q != STEP_HIGH);
    pos_base = bus.pos_clear ? '0 : pos_q;
    if (entering)
      pos_d = dir_q ? pos_base - POS_BITS'(1) : pos_base + POS_BITS'(1);
    else
      pos_d = pos_base;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      vel_q      <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      pend_dir_q <= 1'b0;
      overrun_q  <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
      stp_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      if (bus.velocity_load)
        vel_q <= bus.velocity_in;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
      overrun_q  <= overrun_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      stp_q      <= (state_d == STEP_HIGH);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.stp      = stp_q;
  assign bus.dir      = dir_q;
  assign bus.position = pos_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_stepper_pulsegen.sv
// tb/tb_stepper_pulsegen.sv - directed-vector bench for stepper_pulsegen
// ia: 8-bit rate, 4-bit position, 1-cycle pulses; ib: 10-cycle pulses.
module tb_stepper_pulsegen;

  logic sysclk = 1'b0;
  logic rst_n;
  always #5 sysclk = ~sysclk;

  stepper_pulsegen_if #(.FREQ_BITS(8), .POS_BITS(4)) ia ();
  stepper_pulsegen_if #(.FREQ_BITS(8), .POS_BITS(8)) ib ();

  stepper_pulsegen #(.FREQ_BITS(8), .POS_BITS(4), .PULSE_CYCLES(1), .DIR_SETUP_CYCLES(3)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .bus(ia)
  );
  stepper_pulsegen #(.FREQ_BITS(8), .POS_BITS(8), .PULSE_CYCLES(10), .DIR_SETUP_CYCLES(3)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .bus(ib)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulses, viol, t, gap, cyc, last_rise, bad, high, low;
  logic prev;
  logic [3:0] pos_before, exp4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    ia.velocity_in   = v;
    ia.velocity_load = 1'b1;
    tick();
    ia.velocity_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ia.velocity_in = '0; ia.velocity_load = 1'b0; ia.enable = 1'b0; ia.pos_clear = 1'b0;
    ib.velocity_in = '0; ib.velocity_load = 1'b0; ib.enable = 1'b0; ib.pos_clear = 1'b0;
    repeat (3) tick();
    check("reset_stp", ia.stp, 0);
    check("reset_dir", ia.dir, 0);
    check("reset_pos", ia.position, 0);
    check("reset_busy", ia.busy, 0);
    check("reset_overrun", ia.overrun, 0);
    rst_n = 1'b1;

    // velocity 64 of 256: one carry every 4 cycles, first pulse 5 edges after the load
    ia.enable = 1'b1;
    load_a(8'd64);
    pulses = 0; viol = 0; prev = ia.stp;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ia.stp && !prev) pulses++;
      if (ia.stp && prev) viol++;
      prev = ia.stp;
    end
    check("rate_pulses", pulses, 99);
    check("rate_pos", ia.position, 3);
    check("rate_wide_pulse", viol, 0);
    check("rate_overrun", ia.overrun, 0);

    load_a(8'hC0);
    t = 0;
    while (!ia.dir && t < 40) begin tick(); t++; end
    check("dir_rise", ia.dir, 1);
    check("dir_rise_stp_low", ia.stp, 0);
    pos_before = ia.position;
    gap = 0;
    while (!ia.stp && gap < 40) begin tick(); gap++; end
    check("dir_setup_gap", gap, 3);
    check("dir_held", ia.dir, 1);
    exp4 = pos_before - 4'd1;
    check("dir_step_pos", ia.position, exp4);

    check("ovr_pre", ia.overrun, 0);
    load_a(8'd128);
    t = 0;
    while (!ia.overrun && t < 10) begin tick(); t++; end
    check("ovr_set", ia.overrun, 1);
    load_a(8'd0);
    repeat (5) tick();
    check("ovr_sticky", ia.overrun, 1);

    ia.enable = 1'b0;
    t = 0;
    while (ia.busy && t < 20) begin tick(); t++; end
    ia.pos_clear = 1'b1;
    tick();
    ia.pos_clear = 1'b0;
    check("clr_idle", ia.position, 0);

    // most-negative word: |v| clamps to 127, so pending is always ready and pulses repeat every 3 cycles
    ia.enable = 1'b1;
    load_a(8'h80);
    pulses = 0; bad = 0; cyc = 0; last_rise = 0; prev = ia.stp;
    while (pulses < 17 && cyc < 200) begin
      tick();
      cyc++;
      if (ia.stp && !prev) begin
        pulses++;
        if (pulses == 1) check("sat_wrap_first", ia.position, 15);
        if (pulses >= 2 && (cyc - last_rise) != 3) bad++;
        last_rise = cyc;
      end
      prev = ia.stp;
    end
    check("sat_pulses", pulses, 17);
    check("sat_interval_bad", bad, 0);
    check("sat_dir", ia.dir, 1);
    check("sat_pos_end", ia.position, 15);
    tick();
    tick();
    ia.pos_clear = 1'b1;
    tick();
    check("clr_step_stp", ia.stp, 1);
    check("clr_step_pos", ia.position, 15);
    tick();
    ia.pos_clear = 1'b0;
    check("clr_nostep_pos", ia.position, 0);

    t = 0;
    while (!ia.stp && t < 10) begin tick(); t++; end
    check("rst_pre_stp", ia.stp, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_stp", ia.stp, 0);
    check("rst_mid_dir", ia.dir, 0);
    check("rst_mid_pos", ia.position, 0);
    check("rst_mid_busy", ia.busy, 0);
    check("rst_mid_overrun", ia.overrun, 0);
    rst_n = 1'b1;
    ia.enable = 1'b0;

    ib.velocity_in = 8'd64;
    ib.velocity_load = 1'b1;
    ib.enable = 1'b1;
    tick();
    ib.velocity_load = 1'b0;
    t = 0;
    while (!ib.stp && t < 20) begin tick(); t++; end
    check("dis_first_stp", ib.stp, 1);
    high = 1;
    repeat (2) begin tick(); if (ib.stp) high++; end
    ib.enable = 1'b0;
    t = 0;
    while (t < 30) begin
      tick();
      t++;
      if (!ib.stp) break;
      high++;
    end
    check("dis_high", high, 10);
    low = 0; t = 0;
    while (ib.busy && !ib.stp && t < 40) begin low++; tick(); t++; end
    check("dis_low", low, 10);
    pulses = 0; prev = ib.stp;
    repeat (30) begin
      tick();
      if (ib.stp && !prev) pulses++;
      prev = ib.stp;
    end
    check("dis_no_pulses", pulses, 0);
    check("dis_busy", ib.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
